// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg7_pkg;

    // Active-high hex segment patterns, bit0=a .. bit6=g, indexed by nibble value.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_e;

    function automatic int unsigned pwm_step(input int unsigned slot_cycles,
                                             input int unsigned brightness_bits);
        return slot_cycles >> brightness_bits;
    endfunction

    function automatic int unsigned ctr_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with PWM brightness, guard time, blanking and
// frame-synchronous double-buffered display updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_OF_ANODES    = 4,
    parameter int unsigned SLOT_CYCLES      = 3136,
    parameter int unsigned BRIGHTNESS_BITS  = 4,
    parameter int unsigned GUARD_CYCLES     = 16,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable_i,
    input  logic [4*NUM_OF_ANODES-1:0]   value_i,
    input  logic [NUM_OF_ANODES-1:0]     dp_i,
    input  logic [NUM_OF_ANODES-1:0]     blank_i,
    input  logic [BRIGHTNESS_BITS-1:0]   brightness_i,
    input  logic                         load_i,
    output logic [NUM_OF_ANODES-1:0]     an_o,
    output logic [6:0]                   seg_o,
    output logic                         dp_o,
    output logic                         frame_o
);

    localparam int unsigned PWM_STEP = pwm_step(SLOT_CYCLES, BRIGHTNESS_BITS);
    localparam int unsigned SLOT_W   = ctr_width(SLOT_CYCLES);
    localparam int unsigned DIGIT_W  = ctr_width(NUM_OF_ANODES);

    localparam logic [NUM_OF_ANODES-1:0] AN_OFF  = {NUM_OF_ANODES{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]               SEG_OFF = {7{SEG_ACTIVE_LOW}};

    typedef struct packed {
        logic [NUM_OF_ANODES-1:0][3:0]  value;
        logic [NUM_OF_ANODES-1:0]       dp;
        logic [NUM_OF_ANODES-1:0]       blank;
        logic [BRIGHTNESS_BITS-1:0]     brightness;
    } disp_buf_t;

    scan_state_e          state;
    logic [SLOT_W-1:0]    slot_ctr;
    logic [DIGIT_W-1:0]   digit_idx;
    disp_buf_t            act_buf;
    disp_buf_t            pend_buf;
    logic                 pend_valid;

    logic [3:0]               nibble_c;
    logic [6:0]               seg_hi_c;
    logic                     scanning_c;
    logic                     slot_wrap_c;
    logic                     frame_wrap_c;
    logic                     lit_c;
    logic                     copy_c;
    logic [NUM_OF_ANODES-1:0] an_on_c;

    assign nibble_c = act_buf.value[digit_idx];

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_c),
        .seg_c  (seg_hi_c)
    );

    // Scan position, lit window and buffer-swap decisions for the current cycle.
    always_comb begin
        scanning_c   = (state == ST_SCAN) && enable_i;
        slot_wrap_c  = scanning_c && (32'(slot_ctr) == SLOT_CYCLES - 1);
        frame_wrap_c = slot_wrap_c && (32'(digit_idx) == NUM_OF_ANODES - 1);
        lit_c        = scanning_c
                       && (32'(slot_ctr) >= GUARD_CYCLES)
                       && (32'(slot_ctr) < (32'(act_buf.brightness) + 32'd1) * PWM_STEP)
                       && !act_buf.blank[digit_idx];
        copy_c       = pend_valid && ((state == ST_IDLE) || frame_wrap_c);
        an_on_c      = (NUM_OF_ANODES'(1) << digit_idx) ^ AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            slot_ctr   <= '0;
            digit_idx  <= '0;
            act_buf    <= '0;
            pend_buf   <= '0;
            pend_valid <= 1'b0;
            an_o       <= AN_OFF;
            seg_o      <= SEG_OFF;
            dp_o       <= SEG_ACTIVE_LOW;
            frame_o    <= 1'b0;
        end else begin
            an_o    <= lit_c ? an_on_c : AN_OFF;
            seg_o   <= lit_c ? (seg_hi_c ^ SEG_OFF) : SEG_OFF;
            dp_o    <= lit_c ? (act_buf.dp[digit_idx] ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;
            frame_o <= frame_wrap_c;

            case (state)
                ST_IDLE: begin
                    slot_ctr  <= '0;
                    digit_idx <= '0;
                    if (enable_i) begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!enable_i) begin
                        state     <= ST_IDLE;
                        slot_ctr  <= '0;
                        digit_idx <= '0;
                    end else if (slot_wrap_c) begin
                        slot_ctr  <= '0;
                        digit_idx <= frame_wrap_c ? '0 : digit_idx + 1'b1;
                    end else begin
                        slot_ctr <= slot_ctr + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Swap uses the old pending contents; a same-cycle load waits for the next boundary.
            if (copy_c) begin
                act_buf <= pend_buf;
            end
            if (load_i) begin
                pend_buf.value      <= value_i;
                pend_buf.dp         <= dp_i;
                pend_buf.blank      <= blank_i;
                pend_buf.brightness <= brightness_i;
                pend_valid          <= 1'b1;
            end else if (copy_c) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment display driver for the board top, replacing the fixed "all anodes off" tie-off. It scans NUM_OF_ANODES digits in the system clock domain and decodes a hex nibble per digit. It adds per-digit blanking, decimal points, PWM brightness, anti-ghosting guard time and frame-synchronous double-buffered updates. Status values (e.g. DFU/config state, fabric debug) feed it from the fabric wrapper.

Parameters:
NUM_OF_ANODES, 4, number of digits scanned (1..8)
SLOT_CYCLES, 3136, clk cycles per digit slot (12.5 MHz / 3136 / 4 ≈ 1 kHz frame)
BRIGHTNESS_BITS, 4, brightness resolution; SLOT_CYCLES must be a multiple of 2**BRIGHTNESS_BITS
GUARD_CYCLES, 16, all-off cycles at the start of each slot; must be < SLOT_CYCLES/2**BRIGHTNESS_BITS
ANODE_ACTIVE_LOW, 1, 1: an_o low = digit on
SEG_ACTIVE_LOW, 1, 1: seg_o/dp_o low = segment on

Ports:
clk  input  1  system clock (clk_system, 12.5 MHz)
reset  input  1  synchronous, active-high reset
enable_i  input  1  1: scan; 0: display dark, counters held at 0
value_i  input  4*NUM_OF_ANODES  hex nibbles; nibble k drives digit k (digit 0 = an_o[0])
dp_i  input  NUM_OF_ANODES  decimal point per digit
blank_i  input  NUM_OF_ANODES  1: digit k never lit
brightness_i  input  BRIGHTNESS_BITS  0 = dimmest, max = full slot
load_i  input  1  one-cycle strobe; captures value_i/dp_i/blank_i/brightness_i into the pending buffer
an_o  output  NUM_OF_ANODES  anode drives
seg_o  output  7  segments, bit0=a … bit6=g
dp_o  output  1  decimal point drive
frame_o  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset: an_o, seg_o, dp_o all inactive (all-ones when active-low); frame_o=0; slot_ctr=0; digit_idx=0; active and pending buffers=0 (value 0, dp 0, blank 0, brightness 0); pending_valid=0.
- States: IDLE (enable_i=0) and SCAN. IDLE→SCAN when enable_i=1; starts at digit 0, slot_ctr 0. SCAN→IDLE on the first cycle enable_i=0: counters clear, outputs go inactive on the next edge.
- slot_ctr counts 0..SLOT_CYCLES-1 and wraps. At the wrap, digit_idx increments modulo NUM_OF_ANODES. When digit_idx wraps N-1→0, frame_o pulses for that one cycle.
- Lit condition for the current digit: GUARD_CYCLES ≤ slot_ctr < (brightness_act+1)*PWM_STEP, where PWM_STEP = SLOT_CYCLES>>BRIGHTNESS_BITS. The digit must also have blank_act[digit_idx]=0. At most one anode is active at any time.
- Outputs are registered, with 1-cycle latency from counter state to an_o/seg_o/dp_o. When not lit, all outputs are inactive. Segments carry the decode of the active nibble and dp_act[digit_idx].
- Decode is standard hex gfedcba. Active-high values: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. These are inverted when SEG_ACTIVE_LOW.
- Double buffer: load_i writes pending and sets pending_valid. At a frame boundary (the cycle frame_o pulses) with pending_valid=1, pending is copied to active and pending_valid clears. In IDLE the copy happens on the cycle after load_i. A load_i on the boundary cycle itself is captured into pending and applied at the following boundary.
- Multiple load_i within a frame: the last one wins.
- Reset mid-scan overrides everything, including a pending load.

Decomposition:
- Package seg7_pkg holds the hex→segment constant table (16×7, active-high) and the localparam formulas for PWM_STEP and the counter widths ($clog2).
- Sub-module seg7_hex_decode: purely combinational nibble→7-bit active-high. The polarity inversion happens in seg7_scan_driver.

Test Plan:
Bench parameters: N=4, SLOT_CYCLES=32, BRIGHTNESS_BITS=2, GUARD_CYCLES=2, active-low.
1. Assert reset for 3 cycles, enable_i=1 → an_o=4'b1111, seg_o=7'h7F, dp_o=1, frame_o=0 throughout reset.
2. Apply value_i=16'h1234, brightness_i=3, then load_i while idle, then enable → slot 0: an_o=4'b1110 and seg_o=7'b0011001 ("4") for slot cycles 2..31 (appearing one cycle later); slot 1 shows "3" (7'b0110000) on an_o=4'b1101; frame_o pulses every 128 cycles.
3. Set brightness_i=0 and load → from the next frame each digit is lit only for slot cycles 2..7 and dark for 8..31.
4. In mid-frame, load value_i=16'hABCD → the display keeps 1234 until frame_o; the following frame shows D,C,b,A on digits 0..3. A second load_i (16'h0000) in the same frame → only 0000 appears.
5. Load blank_i=4'b0100 and dp_i=4'b0001 → an_o[2] is never 0; dp_o=0 only while digit 0 is lit.
6. Drop enable_i mid-slot → one cycle later an_o=4'b1111. On re-enable, scanning restarts at digit 0, slot_ctr 0. Asserting reset mid-frame with a pending load → the pending load is discarded and the outputs are inactive.
